// File: rtl/tdc_meas_if.sv
// tdc_meas_if -- bundles the TDC measurement controller's handshake and result bus.
//
// Signals:
//   en, start       : global enable and burst request (consumer -> controller)
//   busy            : controller is not idle
//   launch, cap     : one-cycle TDC start-edge and delay-line capture pulses
//   pc_en, pc_y     : popcount enable (out) and popcount result (in)
//   res_valid/ready : result handshake
//   res_sum/min/max : burst statistics
//   res_ovr/unr     : some sample hit full-scale / zero
//
// Modports:
//   master : the controller side
//   slave  : the environment side (requester, popcount, result consumer)
interface tdc_meas_if #(
    parameter int W        = 7,
    parameter int AVG_LOG2 = 3
);
    logic                    en;
    logic                    start;
    logic                    busy;
    logic                    launch;
    logic                    cap;
    logic                    pc_en;
    logic [W-1:0]            pc_y;
    logic                    res_valid;
    logic                    res_ready;
    logic [W+AVG_LOG2-1:0]   res_sum;
    logic [W-1:0]            res_min;
    logic [W-1:0]            res_max;
    logic                    res_ovr;
    logic                    res_unr;

    modport master (
        input  en, start, pc_y, res_ready,
        output busy, launch, cap, pc_en, res_valid,
               res_sum, res_min, res_max, res_ovr, res_unr
    );

    modport slave (
        output en, start, pc_y, res_ready,
        input  busy, launch, cap, pc_en, res_valid,
               res_sum, res_min, res_max, res_ovr, res_unr
    );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl -- sequences a burst of 2^AVG_LOG2 TDC samples (launch, settle,
// capture, wait for popcount, accumulate) and presents sum/min/max and range
// flags of the burst through a valid/ready result port.
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : tdc_meas_if.master -- en/start in, busy/launch/cap/pc_en out,
//          pc_y in, res_valid/res_* out, res_ready in
module tdc_meas_ctrl #(
    parameter int N        = 64,
    parameter int W        = $clog2(N) + 1,
    parameter int AVG_LOG2 = 3,
    parameter int SETTLE   = 2,
    parameter int PC_LAT   = 2
) (
    input  logic          clk,
    input  logic          rst,
    tdc_meas_if.master    bus
);
    localparam int SW          = W + AVG_LOG2;
    localparam int SCW         = AVG_LOG2 + 1;
    localparam int CNT_MAX     = (SETTLE > PC_LAT) ? SETTLE : PC_LAT;
    localparam int CW          = $clog2(CNT_MAX + 1);
    localparam int SETTLE_LAST = SETTLE - 1;
    // WAIT_PC is unreachable when PC_LAT is 1; keep the terminal count non-negative
    localparam int WAIT_LAST   = (PC_LAT >= 2) ? PC_LAT - 2 : 0;
    localparam logic [SCW-1:0] LAST_SAMPLE = SCW'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SETTLE,
        ST_CAPTURE,
        ST_WAIT_PC,
        ST_ACCUM,
        ST_DONE
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [SCW-1:0]  n_samples;
    logic [SW-1:0]   acc_sum;
    logic [W-1:0]    acc_min, acc_max;
    logic            acc_ovr, acc_unr;

    logic            clear_acc, do_accum, load_res;
    logic [SW-1:0]   sum_upd;
    logic [W-1:0]    min_upd, max_upd;
    logic            ovr_upd, unr_upd;

    // Accumulator values after folding in the current pc_y; the first sample of
    // a burst seeds min/max instead of comparing against stale contents.
    always_comb begin
        sum_upd = acc_sum + SW'(bus.pc_y);
        ovr_upd = acc_ovr | (bus.pc_y == W'(N));
        unr_upd = acc_unr | (bus.pc_y == '0);
        if (n_samples == '0) begin
            min_upd = bus.pc_y;
            max_upd = bus.pc_y;
        end else begin
            min_upd = (bus.pc_y < acc_min) ? bus.pc_y : acc_min;
            max_upd = (bus.pc_y > acc_max) ? bus.pc_y : acc_max;
        end
    end

    // Next-state and strobe decode. Everything is gated by en so a frozen
    // controller neither advances nor emits launch/cap/pc_en, which also keeps
    // exactly one launch and one cap per sample across en toggling.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clear_acc  = 1'b0;
        do_accum   = 1'b0;
        load_res   = 1'b0;
        bus.launch = 1'b0;
        bus.cap    = 1'b0;
        bus.pc_en  = 1'b0;
        if (bus.en) begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_next = ST_LAUNCH;
                        clear_acc  = 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    bus.launch = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == CW'(SETTLE_LAST)) begin
                        cnt_next   = '0;
                        state_next = ST_CAPTURE;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                ST_CAPTURE: begin
                    bus.cap    = 1'b1;
                    bus.pc_en  = 1'b1;
                    cnt_next   = '0;
                    state_next = (PC_LAT == 1) ? ST_ACCUM : ST_WAIT_PC;
                end
                ST_WAIT_PC: begin
                    bus.pc_en = 1'b1;
                    if (cnt == CW'(WAIT_LAST)) begin
                        cnt_next   = '0;
                        state_next = ST_ACCUM;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                ST_ACCUM: begin
                    bus.pc_en = 1'b1;
                    do_accum  = 1'b1;
                    if (n_samples == LAST_SAMPLE) begin
                        load_res   = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_LAUNCH;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.res_valid = (state == ST_DONE);

    // State, counters and accumulators. Results are loaded on the ACCUM->DONE
    // transition from the updated accumulators so the final sample is included,
    // and are otherwise held until the next burst completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            n_samples   <= '0;
            acc_sum     <= '0;
            acc_min     <= '0;
            acc_max     <= '0;
            acc_ovr     <= 1'b0;
            acc_unr     <= 1'b0;
            bus.res_sum <= '0;
            bus.res_min <= '0;
            bus.res_max <= '0;
            bus.res_ovr <= 1'b0;
            bus.res_unr <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (clear_acc) begin
                n_samples <= '0;
                acc_sum   <= '0;
                acc_min   <= '0;
                acc_max   <= '0;
                acc_ovr   <= 1'b0;
                acc_unr   <= 1'b0;
            end
            if (do_accum) begin
                n_samples <= n_samples + SCW'(1);
                acc_sum   <= sum_upd;
                acc_min   <= min_upd;
                acc_max   <= max_upd;
                acc_ovr   <= ovr_upd;
                acc_unr   <= unr_upd;
            end
            if (load_res) begin
                bus.res_sum <= sum_upd;
                bus.res_min <= min_upd;
                bus.res_max <= max_upd;
                bus.res_ovr <= ovr_upd;
                bus.res_unr <= unr_upd;
            end
        end
    end
endmodule

// File: doc/tdc_meas_ctrl.md
TDC_MEAS_CTRL -- requirements
Module: tdc_meas_ctrl

Interface
REQ-001 SHALL have parameter N, default 64: thermometer/delay-line width in taps.
REQ-002 SHALL have parameter W, default $clog2(N)+1: popcount result width.
REQ-003 SHALL have parameter AVG_LOG2, default 3: samples per burst = 2^AVG_LOG2.
REQ-004 SHALL have parameter SETTLE, default 2: cycles from launch to capture, minimum 1.
REQ-005 SHALL have parameter PC_LAT, default 2: cycles from cap to valid pc_y, minimum 1.
REQ-006 SHALL have ports, one per line: name direction width meaning.
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; low freezes the controller
- start  in  1  request one measurement burst
- busy  out  1  high in every state except IDLE
- launch  out  1  one-cycle pulse firing the TDC start edge
- cap  out  1  one-cycle pulse latching the delay line into the popcount input
- pc_en  out  1  popcount enable
- pc_y  in  W  popcount result
- res_valid  out  1  burst result available
- res_ready  in  1  consumer accepts result
- res_sum  out  W+AVG_LOG2  sum of burst samples
- res_min  out  W  minimum sample in burst
- res_max  out  W  maximum sample in burst
- res_ovr  out  1  some sample in burst equalled N (over-range)
- res_unr  out  1  some sample in burst equalled 0 (under-range)

Function
REQ-007 FSM states SHALL be IDLE, LAUNCH, SETTLE, CAPTURE, WAIT_PC, ACCUM, DONE.
REQ-008 IDLE->LAUNCH SHALL occur when start=1 and en=1; start SHALL be ignored in all other states.
REQ-009 LAUNCH SHALL last 1 cycle with launch=1, then go to SETTLE.
REQ-010 SETTLE SHALL last SETTLE cycles, then go to CAPTURE.
REQ-011 CAPTURE SHALL last 1 cycle with cap=1, then go to WAIT_PC.
REQ-012 WAIT_PC SHALL last PC_LAT-1 cycles, then go to ACCUM; with PC_LAT=1 CAPTURE SHALL go directly to ACCUM.
REQ-013 pc_en SHALL be 1 in CAPTURE, WAIT_PC and ACCUM, and 0 elsewhere.
REQ-014 ACCUM SHALL last 1 cycle and sample pc_y exactly PC_LAT cycles after the CAPTURE cycle.
REQ-015 ACCUM SHALL add pc_y into the sum, update min/max (first sample initialises both), OR (pc_y==N) into ovr and OR (pc_y==0) into unr, and increment the sample counter.
REQ-016 After ACCUM the FSM SHALL go to DONE once 2^AVG_LOG2 samples are taken, else to LAUNCH.
REQ-017 Each sample SHALL take 1+SETTLE+1+(PC_LAT-1)+1 cycles (6 at defaults).
REQ-018 Sum width W+AVG_LOG2 SHALL hold N*2^AVG_LOG2 without overflow; no saturation logic.
REQ-019 On DONE entry, res_sum/min/max/ovr/unr SHALL be registered from the accumulators and held stable while res_valid=1.
REQ-020 res_valid SHALL be 1 only in DONE; DONE->IDLE SHALL occur when res_ready=1 (and en=1); a start in that same cycle SHALL be ignored.
REQ-021 Accumulators and sample counter SHALL clear on LAUNCH entry from IDLE.
REQ-022 With en=0 the state, counters and accumulators SHALL hold, and launch, cap and pc_en SHALL be 0; res_valid and res_* SHALL hold their values.
REQ-023 Exactly one launch and one cap pulse SHALL be issued per sample, regardless of en toggling.
REQ-024 res_* SHALL retain the last burst values after leaving DONE until the next DONE entry.

Reset
REQ-025 rst=1 SHALL, at the next edge, force IDLE; clear counters and accumulators; and set busy, launch, cap, pc_en, res_valid, res_sum, res_min, res_max, res_ovr and res_unr to 0.
REQ-026 rst SHALL take priority over en and start in any state, including mid-burst.

Verification
REQ-027 Defaults, pc_y held at 37, start pulsed at cycle 0 -> 8 launch pulses; res_valid first high at cycle 49; res_sum=296, res_min=res_max=37, ovr=unr=0.
REQ-028 pc_y per sample 0,64,10,20,30,40,50,60 -> res_sum=274, res_min=0, res_max=64, res_ovr=1, res_unr=1.
REQ-029 res_ready held low 20 cycles in DONE, with start pulsing -> res_valid and res_* stable, no launch; one cycle after res_ready=1, busy=0.
REQ-030 en low 5 cycles during the first SETTLE -> no launch, cap or pc_en while low; res_valid delayed exactly 5 cycles; still 8 launches.
REQ-031 rst asserted during WAIT_PC of sample 3 -> next cycle all outputs 0 and state IDLE; a new start yields a full fresh 8-sample burst.
REQ-032 start held high, res_ready=1 -> back-to-back bursts with exactly one IDLE cycle between DONE and the next LAUNCH.
